// File: rtl/truth_table_engine_if.sv
// Configuration, lookup and sweep signals of the truth-table engine.
interface truth_table_engine_if #(
  parameter int NIN = 4,
  parameter int NFN = 4
);
  logic                   cfg_we;
  logic [2:0]             cfg_fn;
  logic [2**NIN-1:0]      cfg_data;
  logic                   cfg_err;
  logic                   in_valid;
  logic [NIN-1:0]         in_vec;
  logic                   in_ready;
  logic                   out_valid;
  logic [NIN-1:0]         out_idx;
  logic [NFN-1:0]         out_vec;
  logic                   sweep_start;
  logic                   sweep_busy;
  logic                   sweep_done;
  logic [NFN*(NIN+1)-1:0] sweep_cnt;

  modport master (
    output cfg_we, cfg_fn, cfg_data, in_valid, in_vec, sweep_start,
    input  cfg_err, in_ready, out_valid, out_idx, out_vec,
           sweep_busy, sweep_done, sweep_cnt
  );

  modport slave (
    input  cfg_we, cfg_fn, cfg_data, in_valid, in_vec, sweep_start,
    output cfg_err, in_ready, out_valid, out_idx, out_vec,
           sweep_busy, sweep_done, sweep_cnt
  );
endinterface

// File: rtl/truth_table_engine.sv
// Evaluates NFN programmable NIN-input truth tables per lookup or over an exhaustive sweep.
// Latency: one cycle from an accepted input (or sweep step) to out_valid.
// Backpressure: in_ready is high only in IDLE; inputs offered in SWEEP/DONE are not taken.
module truth_table_engine #(
  parameter int NIN = 4,
  parameter int NFN = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  truth_table_engine_if.slave io
);
  localparam int TW = 2**NIN;
  localparam int CW = NIN + 1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [3:0] NFN_L    = 4'(NFN);
  localparam logic [NIN-1:0] IDX_LAST = {NIN{1'b1}};
  localparam logic [NIN-1:0] IDX_ONE  = {{(NIN-1){1'b0}}, 1'b1};

  logic [1:0]             state;
  logic [TW-1:0]          tbl [NFN];
  logic [CW-1:0]          cnt [NFN];
  logic [NIN-1:0]         sweep_idx;
  logic [NIN-1:0]         lk_idx;
  logic [NFN-1:0]         lk_vec;
  logic                   fn_ok;
  logic                   cfg_err_r;
  logic                   out_valid_r;
  logic [NIN-1:0]         out_idx_r;
  logic [NFN-1:0]         out_vec_r;
  logic [NFN*CW-1:0]      sweep_cnt_r;

  assign fn_ok          = ({1'b0, io.cfg_fn} < NFN_L);
  assign io.in_ready    = (state == ST_IDLE);
  assign io.sweep_busy  = (state == ST_SWEEP);
  assign io.sweep_done  = (state == ST_DONE);
  assign io.cfg_err     = cfg_err_r;
  assign io.out_valid   = out_valid_r;
  assign io.out_idx     = out_idx_r;
  assign io.out_vec     = out_vec_r;
  assign io.sweep_cnt   = sweep_cnt_r;

  // One shared lookup port: the sweep index owns it while sweeping.
  always_comb begin
    lk_vec = '0;
    lk_idx = (state == ST_SWEEP) ? sweep_idx : io.in_vec;
    for (int f = 0; f < NFN; f++) begin
      lk_vec[f] = tbl[f][lk_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_r <= 1'b0;
      for (int f = 0; f < NFN; f++) begin
        tbl[f] <= '0;
      end
    end else begin
      cfg_err_r <= 1'b0;
      if (io.cfg_we) begin
        if (state == ST_IDLE && fn_ok) begin
          for (int f = 0; f < NFN; f++) begin
            if (io.cfg_fn == 3'(f)) tbl[f] <= io.cfg_data;
          end
        end else if (state == ST_SWEEP || !fn_ok) begin
          cfg_err_r <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sweep_idx   <= '0;
      out_valid_r <= 1'b0;
      out_idx_r   <= '0;
      out_vec_r   <= '0;
      sweep_cnt_r <= '0;
      for (int f = 0; f < NFN; f++) begin
        cnt[f] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.sweep_start) begin
            state       <= ST_SWEEP;
            sweep_idx   <= '0;
            out_valid_r <= 1'b0;
            for (int f = 0; f < NFN; f++) begin
              cnt[f] <= '0;
            end
          end else if (io.in_valid) begin
            out_valid_r <= 1'b1;
            out_idx_r   <= io.in_vec;
            out_vec_r   <= lk_vec;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        ST_SWEEP: begin
          out_valid_r <= 1'b1;
          out_idx_r   <= sweep_idx;
          out_vec_r   <= lk_vec;
          for (int f = 0; f < NFN; f++) begin
            cnt[f] <= cnt[f] + CW'(lk_vec[f]);
          end
          // The final step's contribution is folded in directly so the
          // published counts are complete on the DONE cycle.
          if (sweep_idx == IDX_LAST) begin
            state <= ST_DONE;
            for (int f = 0; f < NFN; f++) begin
              sweep_cnt_r[f*CW +: CW] <= cnt[f] + CW'(lk_vec[f]);
            end
          end else begin
            sweep_idx <= sweep_idx + IDX_ONE;
          end
        end
        ST_DONE: begin
          out_valid_r <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          out_valid_r <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_engine.sv
// Directed bench for truth_table_engine (NIN=4, NFN=4) with a small table model.
module tb_truth_table_engine;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [15:0] mdl [4];

  truth_table_engine_if #(.NIN(4), .NFN(4)) bus ();

  truth_table_engine #(.NIN(4), .NFN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sweep capture, filled by run_sweep and judged by the calling test.
  logic [3:0] cap_idx [$];
  logic [3:0] cap_vec [$];
  int         cap_first_vld;
  int         cap_last_vld;
  int         cap_done_n;
  int         cap_done_cyc;
  int         cap_gap;
  logic [19:0] cap_cnt;
  logic       cap_busy1;
  logic       cap_vld1;

  function automatic logic [3:0] expv(input int i);
    logic [3:0] r;
    for (int f = 0; f < 4; f++) r[f] = mdl[f][i];
    return r;
  endfunction

  function automatic logic [4:0] ones(input logic [15:0] t);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + 5'(t[i]);
    return n;
  endfunction

  task automatic idle_inputs();
    bus.cfg_we      = 1'b0;
    bus.cfg_fn      = 3'd0;
    bus.cfg_data    = 16'h0;
    bus.in_valid    = 1'b0;
    bus.in_vec      = 4'h0;
    bus.sweep_start = 1'b0;
  endtask

  task automatic write_tbl(input logic [2:0] fn, input logic [15:0] data);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_fn   = fn;
    bus.cfg_data = data;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
    mdl[fn[1:0]] = data;
  endtask

  task automatic run_sweep(input bit with_vld);
    cap_idx.delete();
    cap_vec.delete();
    cap_first_vld = -1;
    cap_last_vld  = -1;
    cap_done_n    = 0;
    cap_done_cyc  = -1;
    cap_gap       = 0;
    cap_cnt       = '0;
    @(negedge clk);
    bus.sweep_start = 1'b1;
    if (with_vld) begin
      bus.in_valid = 1'b1;
      bus.in_vec   = 4'h9;
    end
    @(negedge clk);
    bus.sweep_start = 1'b0;
    bus.in_valid    = 1'b0;
    cap_busy1 = bus.sweep_busy;
    cap_vld1  = bus.out_valid;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (bus.out_valid) begin
        if (cap_last_vld >= 0 && cap_last_vld != cyc - 1) cap_gap++;
        if (cap_first_vld < 0) cap_first_vld = cyc;
        cap_last_vld = cyc;
        cap_idx.push_back(bus.out_idx);
        cap_vec.push_back(bus.out_vec);
      end
      if (bus.sweep_done) begin
        cap_done_n++;
        cap_done_cyc = cyc;
        cap_cnt      = bus.sweep_cnt;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    for (int f = 0; f < 4; f++) mdl[f] = 16'h0;
    #12;
    checks++;
    if ({bus.out_valid, bus.out_idx, bus.out_vec, bus.cfg_err, bus.sweep_done,
         bus.sweep_busy, bus.sweep_cnt} !== 31'h0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b idx=%h vec=%h err=%b done=%b busy=%b cnt=%h, want all 0",
               bus.out_valid, bus.out_idx, bus.out_vec, bus.cfg_err, bus.sweep_done,
               bus.sweep_busy, bus.sweep_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    // First edge after release must already accept an input.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'h5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'h5 || bus.out_vec !== 4'h0) begin
      errors++;
      $display("FAIL reset_first_lookup: got vld=%b idx=%h vec=%h want 1/5/0",
               bus.out_valid, bus.out_idx, bus.out_vec);
    end
  endtask

  task automatic test_lookup();
    logic [3:0] vecs [4];
    logic [3:0] want [4];
    vecs[0] = 4'h7; vecs[1] = 4'h0; vecs[2] = 4'hB; vecs[3] = 4'hF;
    want[0] = 4'b0100; want[1] = 4'b0000; want[2] = 4'b0100; want[3] = 4'b0101;
    write_tbl(3'd0, 16'h8000);
    write_tbl(3'd2, 16'h8888);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_vec   = vecs[k];
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== vecs[k] || bus.out_vec !== want[k]) begin
        errors++;
        $display("FAIL lookup_%0d: got vld=%b idx=%h vec=%b want 1/%h/%b",
                 k, bus.out_valid, bus.out_idx, bus.out_vec, vecs[k], want[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_idx !== 4'hF || bus.out_vec !== 4'b0101) begin
      errors++;
      $display("FAIL lookup_hold: got vld=%b idx=%h vec=%b want 0/f/0101",
               bus.out_valid, bus.out_idx, bus.out_vec);
    end
  endtask

  task automatic test_write_read_same_cycle();
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_fn   = 3'd1;
    bus.cfg_data = 16'hFFFF;
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'h3;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
    mdl[1]       = 16'hFFFF;
    checks++;
    if (bus.out_vec !== 4'b0100) begin
      errors++;
      $display("FAIL same_cycle_old_data: got vec=%b want 0100", bus.out_vec);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_vec !== 4'b0110) begin
      errors++;
      $display("FAIL same_cycle_new_data: got vec=%b want 0110", bus.out_vec);
    end
    write_tbl(3'd1, 16'h0000);
  endtask

  task automatic test_sweep();
    int bad;
    run_sweep(1'b0);
    bad = 0;
    checks++;
    if (cap_idx.size() != 16 || cap_gap != 0) begin
      errors++;
      $display("FAIL sweep_valid_count: got %0d valids gaps=%0d want 16 consecutive",
               cap_idx.size(), cap_gap);
    end else begin
      for (int i = 0; i < 16; i++)
        if (cap_idx[i] !== 4'(i) || cap_vec[i] !== expv(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_results: %0d of 16 idx/vec pairs wrong, want 0", bad);
    end
    checks++;
    if (cap_done_n != 1 || cap_done_cyc < cap_last_vld) begin
      errors++;
      $display("FAIL sweep_done_pulse: got %0d pulses at cyc %0d last vld %0d want 1 at/after last",
               cap_done_n, cap_done_cyc, cap_last_vld);
    end
    checks++;
    if (cap_cnt !== {5'd0, 5'd4, 5'd0, 5'd1}) begin
      errors++;
      $display("FAIL sweep_cnt: got %h want %h", cap_cnt, {5'd0, 5'd4, 5'd0, 5'd1});
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.sweep_cnt !== {5'd0, 5'd4, 5'd0, 5'd1}) begin
      errors++;
      $display("FAIL sweep_after: got ready=%b cnt=%h want 1/%h",
               bus.in_ready, bus.sweep_cnt, {5'd0, 5'd4, 5'd0, 5'd1});
    end
  endtask

  task automatic test_cfg_err();
    int waited;
    @(negedge clk);
    bus.sweep_start = 1'b1;
    @(negedge clk);
    bus.sweep_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_fn   = 3'd0;
    bus.cfg_data = 16'hFFFF;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    checks++;
    if (bus.cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_sweep: got %b want 1", bus.cfg_err);
    end
    @(negedge clk);
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_one_cycle: got %b want 0", bus.cfg_err);
    end
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 40) begin
      errors++;
      $display("FAIL cfg_err_sweep_end: timeout waiting for idle, got ready=%b want 1", bus.in_ready);
    end
    bus.cfg_we   = 1'b1;
    bus.cfg_fn   = 3'd5;
    bus.cfg_data = 16'hFFFF;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    checks++;
    if (bus.cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_bad_fn: got %b want 1", bus.cfg_err);
    end
    for (int v = 0; v < 16; v += 5) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_vec   = 4'(v);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_vec !== expv(v)) begin
        errors++;
        $display("FAIL cfg_err_tables_kept v=%0d: got vec=%b want %b", v, bus.out_vec, expv(v));
      end
    end
  endtask

  task automatic test_overflow();
    logic [19:0] want;
    write_tbl(3'd1, 16'hFFFF);
    run_sweep(1'b0);
    want = {ones(mdl[3]), ones(mdl[2]), ones(mdl[1]), ones(mdl[0])};
    checks++;
    if (cap_done_n != 1 || cap_cnt !== want || cap_cnt[9:5] !== 5'd16) begin
      errors++;
      $display("FAIL overflow_cnt: got pulses=%0d cnt=%h want 1/%h", cap_done_n, cap_cnt, want);
    end
  endtask

  task automatic test_start_with_valid();
    run_sweep(1'b1);
    checks++;
    if (cap_busy1 !== 1'b1 || cap_vld1 !== 1'b0) begin
      errors++;
      $display("FAIL start_drops_input: got busy=%b vld=%b want 1/0", cap_busy1, cap_vld1);
    end
    checks++;
    if (cap_idx.size() != 16 || cap_idx[0] !== 4'h0) begin
      errors++;
      $display("FAIL start_first_idx: got n=%0d first=%h want 16/0",
               cap_idx.size(), (cap_idx.size() > 0) ? cap_idx[0] : 4'hx);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int waited;
    int done_seen;
    @(negedge clk);
    bus.sweep_start = 1'b1;
    @(negedge clk);
    bus.sweep_start = 1'b0;
    waited = 0;
    while (!(bus.out_valid === 1'b1 && bus.out_idx === 4'h7) && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 30) begin
      errors++;
      $display("FAIL rst_mid_reach_step7: timeout, got idx=%h want 7", bus.out_idx);
    end
    rst_n = 1'b0;
    for (int f = 0; f < 4; f++) mdl[f] = 16'h0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_idx, bus.out_vec, bus.cfg_err, bus.sweep_done,
         bus.sweep_busy, bus.sweep_cnt} !== 31'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got vld=%b idx=%h vec=%h err=%b done=%b busy=%b cnt=%h want all 0",
               bus.out_valid, bus.out_idx, bus.out_vec, bus.cfg_err, bus.sweep_done,
               bus.sweep_busy, bus.sweep_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.sweep_done === 1'b1 || bus.sweep_busy === 1'b1 || bus.sweep_cnt !== 20'h0)
        done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL rst_mid_no_done: %0d cycles with done/busy/cnt activity, want 0", done_seen);
    end
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'hF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_vec !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_tables_cleared: got vec=%b want 0000", bus.out_vec);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lookup();
    test_write_read_same_cycle();
    test_sweep();
    test_cfg_err();
    test_start_with_valid();
    test_overflow();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/truth_table_engine.md
TRUTH_TABLE_ENGINE -- requirements
Module: truth_table_engine

Interface
REQ-001 SHALL have parameter NIN, default 4, number of function inputs (2..8).
REQ-002 SHALL have parameter NFN, default 4, number of independent functions (1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_we  input  1  truth-table write strobe.
REQ-006 SHALL have port cfg_fn  input  3  function index for the write.
REQ-007 SHALL have port cfg_data  input  2^NIN  truth table; bit k is the output for input vector k.
REQ-008 SHALL have port cfg_err  output  1  one-cycle pulse when a write is rejected.
REQ-009 SHALL have port in_valid  input  1  input vector present.
REQ-010 SHALL have port in_vec  input  NIN  input vector; bit NIN-1 is the MSB.
REQ-011 SHALL have port in_ready  output  1  high only in IDLE.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_idx  output  NIN  input vector that produced out_vec.
REQ-014 SHALL have port out_vec  output  NFN  bit f is the value of function f.
REQ-015 SHALL have port sweep_start  input  1  request an exhaustive sweep.
REQ-016 SHALL have port sweep_busy  output  1  high in SWEEP.
REQ-017 SHALL have port sweep_done  output  1  one-cycle pulse after the final sweep result.
REQ-018 SHALL have port sweep_cnt  output  NFN*(NIN+1)  slice f is the count of ones of function f over the last sweep.

Function
REQ-019 SHALL store NFN truth tables of 2^NIN bits each.
REQ-020 SHALL load cfg_data into table cfg_fn on a cycle with cfg_we=1, state IDLE and cfg_fn<NFN.
REQ-021 SHALL drop the write and pulse cfg_err for one cycle when cfg_we=1 and either state is SWEEP or cfg_fn>=NFN.
REQ-022 SHALL, when in_valid=1 and in_ready=1, drive out_valid=1 on the next cycle, with out_idx=in_vec and out_vec[f]=table_f[in_vec]; latency is exactly 1 cycle.
REQ-023 SHALL use the table contents present before the edge when a write and a lookup occur in the same cycle (old data).
REQ-024 SHALL have FSM states IDLE, SWEEP and DONE.
REQ-025 SHALL transition IDLE->SWEEP on sweep_start=1; sweep_start SHALL take priority over a simultaneous in_valid, and that input SHALL be dropped.
REQ-026 SHALL, in SWEEP, step an internal index from 0 to 2^NIN-1, one per cycle, emitting each result as in REQ-022 (out_valid high for 2^NIN consecutive cycles).
REQ-027 SHALL clear the per-function ones counters on entry to SWEEP and accumulate out_vec[f] into counter f each sweep step; counter width NIN+1 (holds 2^NIN without wrap).
REQ-028 SHALL transition SWEEP->DONE after the index reaches 2^NIN-1, with no index wrap, then DONE->IDLE unconditionally; sweep_done=1 only in DONE.
REQ-029 SHALL update sweep_cnt only on entry to DONE and hold it until the next sweep completes.
REQ-030 SHALL ignore sweep_start while in SWEEP or DONE.
REQ-031 SHALL hold out_idx and out_vec unchanged when out_valid=0.

Reset
REQ-032 SHALL, on rst_n=0, immediately set the state to IDLE, all tables to 0, the sweep index to 0, all counters and sweep_cnt to 0, and out_valid, out_idx, out_vec, cfg_err, sweep_done and sweep_busy to 0.
REQ-033 SHALL, when reset asserts mid-sweep, abort the sweep with no sweep_done pulse and no sweep_cnt update.
REQ-034 SHALL first accept input on the first rising edge after rst_n deasserts; in_ready=1 from deassertion.

Verification (NIN=4, NFN=4)
REQ-035 SHALL cover: write fn0=16'h8000, fn2=16'h8888; in_vec=4'hF -> next cycle out_vec=4'b0101, out_idx=15.
REQ-036 SHALL cover: same tables, sweep_start -> 16 out_valid cycles with idx 0..15, then sweep_done pulse with sweep_cnt slices {fn3=0, fn2=4, fn1=0, fn0=1}.
REQ-037 SHALL cover: cfg_we during SWEEP, and cfg_fn=5 in IDLE -> cfg_err pulse each time, tables unchanged.
REQ-038 SHALL cover: fn1=16'hFFFF, sweep -> slice fn1=16 (no overflow).
REQ-039 SHALL cover: rst_n low at sweep step 7 -> all outputs 0, no sweep_done, sweep_cnt=0.
REQ-040 SHALL cover: sweep_start with in_valid in the same cycle -> input dropped, first result out_idx=0.
